// File: rtl/wb_sram_port0_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_sram_port0_bridge_if
//
// Wishbone classic bus bundle for wb_sram_port0_bridge.
//   master modport : drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave modport  : the mirror image, used by the bridge
//
// Optional feature macro: WB_SRAM_BRIDGE_ERR_EN adds the wb_err_o signal.
// ---------------------------------------------------------------------------
interface wb_sram_port0_bridge_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
`ifdef WB_SRAM_BRIDGE_ERR_EN
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o, wb_err_o
  );
`else
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
`endif
endinterface

// File: rtl/wb_sram_port0_bridge.sv
// ---------------------------------------------------------------------------
// wb_sram_port0_bridge
//
// Wishbone classic slave mapping a 4*2^ADDR_WIDTH byte window at BASE_ADDR
// onto the RW port (port 0) of a 256x32 dual-port OpenRAM macro.
//
// Ports:
//   clk          single clock, also the macro's clk0
//   rst_n        asynchronous active-low reset
//   wb           Wishbone slave bundle (cyc/stb/we/sel/adr/dat_i, ack/dat_o)
//   sram_csb0    active-low chip select (combinational from the bus)
//   sram_web0    active-low write enable
//   sram_wmask0  byte write mask
//   sram_addr0   word address
//   sram_din0    write data
//   sram_dout0   macro read data, valid only between the falling edge and
//                the next rising edge after a read is sampled
//
// Latency: write request -> ack 2 cycles, read request -> ack 3 cycles.
//
// Optional feature macro: WB_SRAM_BRIDGE_ERR_EN. When defined, a write with
// an all-zero byte select is not issued to the macro and is answered with
// wb_err_o instead of wb_ack_o.
// ---------------------------------------------------------------------------
module wb_sram_port0_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_sram_port0_bridge_if.slave wb,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int TAG_LSB = ADDR_WIDTH + 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  hit;
  logic                  req;
  logic                  accept;
  logic                  bad_write;
  logic                  sram_go;
  logic                  resp_busy;
  logic                  ack_q;
  logic                  err_flag;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  unused_adr;

  // Byte offset bits carry no information for a word-wide macro.
  assign unused_adr = ^wb.wb_adr_i[1:0];

  assign hit = (wb.wb_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign req = wb.wb_cyc_i & wb.wb_stb_i & hit;

  // The response cycle (ack/err high) still belongs to the finished transfer:
  // the master keeps stb high until it has seen ack, so accepting again here
  // would repeat the access. This gives the 3/4-cycle minimum spacing.
  assign accept = (state == ST_IDLE) & req & ~resp_busy;

`ifdef WB_SRAM_BRIDGE_ERR_EN
  logic err_q;

  assign bad_write = wb.wb_we_i & (wb.wb_sel_i == 4'b0000);
  assign resp_busy = ack_q | err_q;
  assign wb.wb_err_o = err_q;
`else
  assign bad_write = 1'b0;
  assign resp_busy = ack_q;
`endif

  // Macro signals are combinational so the macro samples the request on the
  // same edge the FSM leaves IDLE. rst_n gates csb so reset alone idles it.
  assign sram_go     = accept & ~bad_write;
  assign sram_csb0   = ~(sram_go & rst_n);
  assign sram_web0   = ~wb.wb_we_i;
  assign sram_wmask0 = wb.wb_sel_i;
  assign sram_addr0  = wb.wb_adr_i[ADDR_WIDTH+1:2];
  assign sram_din0   = wb.wb_dat_i;

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (accept) state_nxt = wb.wb_we_i ? ST_ACK : ST_RD_WAIT;
      ST_RD_WAIT: state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
`ifdef WB_SRAM_BRIDGE_ERR_EN
      err_q    <= 1'b0;
      err_flag <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // The response is registered one cycle behind the ACK state.
      ack_q <= (state == ST_ACK) & ~err_flag;
      // sram_dout0 is only valid up to this edge; capture it here and hold it
      // until the next read.
      if (state == ST_RD_WAIT) dat_q <= sram_dout0;
`ifdef WB_SRAM_BRIDGE_ERR_EN
      err_q <= (state == ST_ACK) & err_flag;
      if (accept) err_flag <= bad_write;
`endif
    end
  end

`ifndef WB_SRAM_BRIDGE_ERR_EN
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram_port0_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_sram_port0_bridge
//
// Directed bench for wb_sram_port0_bridge with a behavioural model of the
// OpenRAM port 0: the request is sampled on the rising edge, the write or
// read happens on the following falling edge, and read data turns to X
// shortly after the next rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_sram_port0_bridge;

  logic        clk;
  logic        rst_n;
  logic        csb;
  logic        web;
  logic [3:0]  wmask;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  int checks   = 0;
  int failures = 0;

  wb_sram_port0_bridge_if wb ();

  wb_sram_port0_bridge #(
    .BASE_ADDR (32'h3000_0000),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (wb.slave),
    .sram_csb0  (csb),
    .sram_web0  (web),
    .sram_wmask0(wmask),
    .sram_addr0 (addr),
    .sram_din0  (din),
    .sram_dout0 (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM port 0 model ----------------
  logic [31:0] mem [256];
  logic        s_pend;
  logic        s_we;
  logic [7:0]  s_addr;
  logic [3:0]  s_mask;
  logic [31:0] s_din;
  int          acc_cnt = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h5A5A_0000;
    dout   = 32'hx;
  end

  always begin
    @(posedge clk);
    s_pend = !csb;
    s_we   = !web;
    s_addr = addr;
    s_mask = wmask;
    s_din  = din;
    if (s_pend) acc_cnt++;
    #1 dout = 32'hx;
    @(negedge clk);
    if (s_pend) begin
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_mask[b]) mem[s_addr][8*b +: 8] = s_din[8*b +: 8];
      end else begin
        dout = mem[s_addr];
      end
    end
  end

  // ---------------- bus transfer helper (no comparisons) ----------------
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, input int max_cyc,
                      output int lat, output int n_ack, output int n_err, output int n_csb,
                      output logic [31:0] rdat, output logic [7:0] req_addr,
                      output logic [3:0] req_mask);
    logic seen;
    @(posedge clk);
    #1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_sel_i = sel;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = wdat;
    @(negedge clk);
    req_addr = addr;
    req_mask = wmask;
    n_csb    = csb ? 0 : 1;
    lat      = 0;
    n_ack    = 0;
    n_err    = 0;
    rdat     = 32'h0;
    seen     = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk);
      if (seen) begin
        #1;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
      end
      @(negedge clk);
      if (!csb) n_csb++;
      if (wb.wb_ack_o) n_ack++;
`ifdef WB_SRAM_BRIDGE_ERR_EN
      if (wb.wb_err_o) n_err++;
      if ((wb.wb_ack_o || wb.wb_err_o) && !seen) begin
`else
      if (wb.wb_ack_o && !seen) begin
`endif
        lat  = i;
        rdat = wb.wb_dat_o;
        seen = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'hF;
    wb.wb_adr_i = 32'h3000_0010;
    wb.wb_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (csb !== 1'b1) begin failures++; $display("FAIL reset_csb: got %b want 1", csb); end
    checks++;
    if (wb.wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", wb.wb_ack_o); end
    checks++;
    if (wb.wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat: got %h want 0", wb.wb_dat_o); end
    checks++;
    if (acc_cnt !== 0) begin failures++; $display("FAIL reset_access: got %0d want 0", acc_cnt); end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write_read();
    int lat, na, ne, nc;
    logic [31:0] rd;
    logic [7:0] ra;
    logic [3:0] rm;
    xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 8, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++;
    if (na !== 1 || nc !== 1) begin failures++; $display("FAIL wr_single: acks %0d csb_lows %0d want 1 1", na, nc); end
    xfer(1'b0, 32'h3000_0010, 4'h0, 32'h0, 8, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (ra !== 8'h04) begin failures++; $display("FAIL rd_addr: got %h want 04", ra); end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d want 3", lat); end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++;
    if (na !== 1 || nc !== 1) begin failures++; $display("FAIL rd_single: acks %0d csb_lows %0d want 1 1", na, nc); end
  endtask

  task automatic test_byte_merge();
    int lat, na, ne, nc;
    logic [31:0] rd;
    logic [7:0] ra;
    logic [3:0] rm;
    xfer(1'b1, 32'h3000_03FC, 4'hF, 32'h1122_3344, 8, lat, na, ne, nc, rd, ra, rm);
    xfer(1'b1, 32'h3000_03FC, 4'b0101, 32'hAABB_CCDD, 8, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (rm !== 4'b0101) begin failures++; $display("FAIL merge_mask: got %b want 0101", rm); end
    checks++;
    if (wb.wb_dat_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dat_hold_on_write: got %h want deadbeef", wb.wb_dat_o); end
    xfer(1'b0, 32'h3000_03FC, 4'h0, 32'h0, 8, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (ra !== 8'hFF) begin failures++; $display("FAIL merge_addr: got %h want ff", ra); end
    checks++;
    if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL merge_data: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_out_of_window();
    int lat, na, ne, nc, acc0;
    logic [31:0] rd;
    logic [7:0] ra;
    logic [3:0] rm;
    acc0 = acc_cnt;
    xfer(1'b1, 32'h3000_0400, 4'hF, 32'hFFFF_FFFF, 10, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (na !== 0 || nc !== 0) begin failures++; $display("FAIL oow_high: acks %0d csb_lows %0d want 0 0", na, nc); end
    xfer(1'b1, 32'h2FFF_FFFC, 4'hF, 32'hFFFF_FFFF, 10, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (na !== 0 || nc !== 0) begin failures++; $display("FAIL oow_low: acks %0d csb_lows %0d want 0 0", na, nc); end
    checks++;
    if (acc_cnt !== acc0) begin failures++; $display("FAIL oow_access: got %0d want %0d", acc_cnt, acc0); end
    xfer(1'b0, 32'h3000_0000, 4'h0, 32'h0, 8, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (rd !== 32'h5A5A_0000) begin failures++; $display("FAIL oow_word0: got %h want 5a5a0000", rd); end
    xfer(1'b0, 32'h3000_03FC, 4'h0, 32'h0, 8, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL oow_word255: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] csb_mask;
    logic [8:0] ack_mask;
    logic [31:0] rd;
    // Writes with stb held high: accepted every 3 cycles.
    @(posedge clk);
    #1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b1;
    wb.wb_sel_i = 4'hF;
    wb.wb_adr_i = 32'h3000_0040;
    wb.wb_dat_i = 32'hA5A5_0001;
    csb_mask = '0;
    ack_mask = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      csb_mask[k] = !csb;
      ack_mask[k] = wb.wb_ack_o;
      if (k != 6) @(posedge clk);
    end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    checks++;
    if (csb_mask[6:0] !== 7'b1001001) begin failures++; $display("FAIL b2b_wr_csb: got %b want 1001001", csb_mask[6:0]); end
    checks++;
    if (ack_mask[6:0] !== 7'b0100100) begin failures++; $display("FAIL b2b_wr_ack: got %b want 0100100", ack_mask[6:0]); end
    repeat (3) @(posedge clk);
    // Reads with stb held high: accepted every 4 cycles.
    #1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b0;
    csb_mask = '0;
    ack_mask = '0;
    rd = 32'h0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      csb_mask[k] = !csb;
      ack_mask[k] = wb.wb_ack_o;
      if (k == 3) rd = wb.wb_dat_o;
      if (k != 8) @(posedge clk);
    end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    checks++;
    if (csb_mask !== 9'b100010001) begin failures++; $display("FAIL b2b_rd_csb: got %b want 100010001", csb_mask); end
    checks++;
    if (ack_mask !== 9'b010001000) begin failures++; $display("FAIL b2b_rd_ack: got %b want 010001000", ack_mask); end
    checks++;
    if (rd !== 32'hA5A5_0001) begin failures++; $display("FAIL b2b_rd_data: got %h want a5a50001", rd); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_read();
    int lat, na, ne, nc, n_ack;
    logic [31:0] rd;
    logic [7:0] ra;
    logic [3:0] rm;
    @(posedge clk);
    #1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'hF;
    wb.wb_adr_i = 32'h3000_0010;
    @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    #1;
    checks++;
    if (wb.wb_dat_o !== 32'h0) begin failures++; $display("FAIL midrst_dat: got %h want 0", wb.wb_dat_o); end
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_ack = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb.wb_ack_o) n_ack++;
    end
    checks++;
    if (n_ack !== 0) begin failures++; $display("FAIL midrst_ack: got %0d acks want 0", n_ack); end
    checks++;
    if (wb.wb_dat_o !== 32'h0) begin failures++; $display("FAIL midrst_dat_after: got %h want 0", wb.wb_dat_o); end
    xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 8, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (lat !== 3 || rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL midrst_next_read: lat %0d data %h want 3 deadbeef", lat, rd); end
  endtask

  task automatic test_sel_zero();
    int lat, na, ne, nc;
    logic [31:0] rd;
    logic [7:0] ra;
    logic [3:0] rm;
    xfer(1'b1, 32'h3000_0020, 4'hF, 32'h1234_5678, 8, lat, na, ne, nc, rd, ra, rm);
    xfer(1'b1, 32'h3000_0020, 4'h0, 32'hFFFF_FFFF, 8, lat, na, ne, nc, rd, ra, rm);
`ifdef WB_SRAM_BRIDGE_ERR_EN
    checks++;
    if (ne !== 1 || lat !== 2) begin failures++; $display("FAIL sel0_err: errs %0d lat %0d want 1 2", ne, lat); end
    checks++;
    if (na !== 0 || nc !== 0) begin failures++; $display("FAIL sel0_quiet: acks %0d csb_lows %0d want 0 0", na, nc); end
`else
    checks++;
    if (na !== 1 || lat !== 2) begin failures++; $display("FAIL sel0_ack: acks %0d lat %0d want 1 2", na, lat); end
    checks++;
    if (nc !== 1 || rm !== 4'h0) begin failures++; $display("FAIL sel0_issue: csb_lows %0d mask %b want 1 0000", nc, rm); end
`endif
    xfer(1'b0, 32'h3000_0020, 4'h0, 32'h0, 8, lat, na, ne, nc, rd, ra, rm);
    checks++;
    if (rd !== 32'h1234_5678) begin failures++; $display("FAIL sel0_data: got %h want 12345678", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_merge();
    test_out_of_window();
    test_back_to_back();
    test_reset_mid_read();
    test_sel_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
